// File: rtl/div_seq_ctrl.sv
// Multi-cycle DIV/DIVU sequencer with restoring shift-subtract datapath.
// Optional DIV_ZERO_FAST_EN: a zero divisor completes in one cycle instead of WIDTH.
module div_seq_ctrl #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 startE,
   input  logic                 signedE,
   input  logic [WIDTH-1:0]     srcaE,
   input  logic [WIDTH-1:0]     srcbE,
   input  logic                 annulE,
   output logic                 div_stallE,
   output logic                 div_readyE,
   output logic [2*WIDTH-1:0]   result_o
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state, state_nx;
   logic [CW-1:0]     cnt;
   logic [WIDTH-1:0]  rem, quo, dvs;
   logic              sign_q, sign_r;

   logic [WIDTH-1:0]  a_abs, b_abs;
   logic              b_zero;
   logic [WIDTH:0]    rem_wide, rem_diff;
   logic [WIDTH-1:0]  rem_step, quo_step, rem_fix, quo_fix;
   logic              load, step, finish, fast_done;

   // Operand magnitudes and one restoring step with its sign-fixed result
   always_comb begin
      a_abs    = (signedE & srcaE[WIDTH-1]) ? (~srcaE + WIDTH'(1)) : srcaE;
      b_abs    = (signedE & srcbE[WIDTH-1]) ? (~srcbE + WIDTH'(1)) : srcbE;
      b_zero   = (srcbE == '0);
      rem_wide = {rem, quo[WIDTH-1]};
      rem_diff = rem_wide - {1'b0, dvs};
      if (!rem_diff[WIDTH]) begin
         rem_step = rem_diff[WIDTH-1:0];
         quo_step = {quo[WIDTH-2:0], 1'b1};
      end else begin
         rem_step = rem_wide[WIDTH-1:0];
         quo_step = {quo[WIDTH-2:0], 1'b0};
      end
      // A zero divisor leaves |a| in rem; sign_r then restores the raw dividend
      quo_fix  = sign_q ? (~quo_step + WIDTH'(1)) : quo_step;
      rem_fix  = sign_r ? (~rem_step + WIDTH'(1)) : rem_step;
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next state, datapath controls and the combinational stall request
   always_comb begin
      state_nx   = state;
      load       = 1'b0;
      step       = 1'b0;
      finish     = 1'b0;
      fast_done  = 1'b0;
      div_stallE = 1'b0;
      case (state)
         IDLE: begin
            if (startE) begin
               load = 1'b1;
`ifdef DIV_ZERO_FAST_EN
               if (b_zero) begin
                  fast_done = 1'b1;
                  state_nx  = DONE;
               end else begin
                  state_nx  = BUSY;
               end
`else
               state_nx = BUSY;
`endif
            end
         end
         BUSY: begin
            step = 1'b1;
            if (cnt == LAST) begin
               finish   = 1'b1;
               state_nx = DONE;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      // Annul wins over everything: no load, no completion, back to idle
      if (annulE) begin
         state_nx  = IDLE;
         load      = 1'b0;
         step      = 1'b0;
         finish    = 1'b0;
         fast_done = 1'b0;
      end
      div_stallE = ~rst & ~annulE &
                   (((state == IDLE) & startE) | (state == BUSY));
   end

   // Datapath registers, ready pulse and result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         rem        <= '0;
         quo        <= '0;
         dvs        <= '0;
         sign_q     <= 1'b0;
         sign_r     <= 1'b0;
         div_readyE <= 1'b0;
         result_o   <= '0;
      end else begin
         div_readyE <= finish | fast_done;
         if (load) begin
            cnt    <= '0;
            rem    <= '0;
            quo    <= a_abs;
            dvs    <= b_abs;
            sign_q <= signedE & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]) & ~b_zero;
            sign_r <= signedE & srcaE[WIDTH-1];
         end
         if (step) begin
            rem <= rem_step;
            quo <= quo_step;
            cnt <= cnt + CW'(1);
         end
         if (finish)    result_o <= {rem_fix, quo_fix};
         if (fast_done) result_o <= {srcaE, {WIDTH{1'b1}}};
      end
   end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: directed table, random vs arithmetic model,
// annul and mid-divide reset sequences. Honours DIV_ZERO_FAST_EN for latency.
module tb_div_seq_ctrl;

   logic        clk, rst, startE, signedE, annulE;
   logic [31:0] srcaE, srcbE;
   logic        div_stallE, div_readyE;
   logic [63:0] result_o;

   int chk = 0;
   int err = 0;

   div_seq_ctrl #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .startE(startE), .signedE(signedE),
      .srcaE(srcaE), .srcbE(srcbE), .annulE(annulE),
      .div_stallE(div_stallE), .div_readyE(div_readyE), .result_o(result_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        s;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Reference: plain signed/unsigned arithmetic, remainder takes dividend sign
   function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'h0) return {a, 32'hFFFF_FFFF};
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = sa / sb;
         r  = sa % sb;
         return {r[31:0], q[31:0]};
      end
      return {a % b, a / b};
   endfunction

   function automatic int exp_lat(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
      if (b == 32'h0) return 1;
`endif
      return 33;
   endfunction

   // Called #1 after a rising edge in an IDLE cycle (T0); returns #1 after the edge following ready
   task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] res, output int lat, output int stalls);
      res = '0; lat = -1; stalls = 0;
      signedE = s; srcaE = a; srcbE = b; startE = 1'b1;
      #1;
      for (int t = 0; t < 40; t++) begin
         if (div_stallE) stalls++;
         if (div_readyE) begin
            lat = t;
            res = result_o;
            break;
         end
         @(posedge clk); #1;
         startE = 1'b0;
         srcaE  = $urandom;
         srcbE  = $urandom;
      end
      @(posedge clk); #1;
   endtask

   task automatic do_check(input string name, input logic s, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp);
      logic [63:0] res;
      int lat, stalls;
      run_div(s, a, b, res, lat, stalls);
      check({name, " result"}, res, exp);
      check({name, " latency"}, 64'(lat), 64'(exp_lat(b)));
      check({name, " stall_cycles"}, 64'(stalls), 64'(exp_lat(b)));
   endtask

   vec_t        vecs[8];
   logic [63:0] last_exp;
   logic [63:0] res;
   int          lat, stalls, readies;
   logic        rs;
   logic [31:0] ra, rb;

   initial begin
      vecs[0] = '{1'b0, 32'd7,          32'd2,          {32'h1,        32'h3}};
      vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}};
      vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  {32'h1,        32'hFFFF_FFFD}};
      vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h0,        32'h8000_0000}};
      vecs[4] = '{1'b0, 32'd5,          32'd0,          {32'h5,        32'hFFFF_FFFF}};
      vecs[5] = '{1'b1, 32'hFFFF_FFF8,  32'd0,          {32'hFFFF_FFF8, 32'hFFFF_FFFF}};
      vecs[6] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          {32'h0,        32'hFFFF_FFFF}};
      vecs[7] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h8000_0000, 32'h0}};

      rst = 1'b1; startE = 1'b0; signedE = 1'b0; annulE = 1'b0; srcaE = '0; srcbE = '0;
      #1;
      check("reset stall", 64'(div_stallE), 64'd0);
      check("reset ready", 64'(div_readyE), 64'd0);
      check("reset result", result_o, 64'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // Directed table, back-to-back with no idle bubble beyond the required one
      foreach (vecs[i]) begin
         do_check($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp);
         last_exp = vecs[i].exp;
      end

      // Annul at T10: no ready, result held; then DIVU 9/3 at T12
      signedE = 1'b0; srcaE = 32'd100; srcbE = 32'd7; startE = 1'b1;
      readies = 0;
      for (int t = 0; t < 10; t++) begin
         #1;
         if (div_readyE) readies++;
         @(posedge clk); #1;
         startE = 1'b0;
      end
      annulE = 1'b1; #1;
      check("annul stall", 64'(div_stallE), 64'd0);
      @(posedge clk); #1;
      annulE = 1'b0; #1;
      check("annul idle stall", 64'(div_stallE), 64'd0);
      if (div_readyE) readies++;
      check("annul result held", result_o, last_exp);
      @(posedge clk); #1;
      if (div_readyE) readies++;
      check("annul no ready", 64'(readies), 64'd0);
      do_check("after annul 9/3", 1'b0, 32'd9, 32'd3, {32'h0, 32'h3});
      last_exp = {32'h0, 32'h3};

      // Asynchronous reset at T5 of a divide
      signedE = 1'b1; srcaE = 32'd1000; srcbE = 32'd9; startE = 1'b1;
      for (int t = 0; t < 5; t++) begin
         @(posedge clk); #1;
         startE = 1'b0;
      end
      check("midbusy stall before rst", 64'(div_stallE), 64'd1);
      rst = 1'b1; #1;
      check("rst stall", 64'(div_stallE), 64'd0);
      check("rst result", result_o, 64'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      do_check("after rst", 1'b1, 32'd1000, 32'd9, ref_div(1'b1, 32'd1000, 32'd9));

      // Random divides against the arithmetic model
      for (int i = 0; i < 40; i++) begin
         rs = 1'($urandom);
         case ($urandom_range(0, 5))
            0:       begin ra = $urandom; rb = 32'h0; end
            1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2:       begin ra = $urandom; rb = $urandom_range(1, 15); end
            3:       begin ra = $urandom; rb = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)); end
            default: begin ra = $urandom; rb = $urandom; end
         endcase
         do_check($sformatf("rand%0d", i), rs, ra, rb, ref_div(rs, ra, rb));
      end

      $display("CHECKS %0d ERRORS %0d", chk, err);
      $finish;
   end

endmodule
